// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer and sole driver of the PC's control inputs.
// It arbitrates between a taken branch from EX, a jump from ID, a halt, the load-use
// hazard and instruction-memory wait. It also brings the PC to RESET_VEC after reset,
// issues pipeline flushes and keeps a saturating count of stall cycles.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_ready          instruction word at the current PC is available this cycle
//   load_use            load-use hazard detected in ID
//   br_taken, br_target branch resolved taken in EX, and its target
//   jmp_req, jmp_target jump decoded in ID, and its target
//   halt                halt instruction in ID
//   stall               hold the PC
//   jump_cs, Next_pc    load Next_pc into the PC; Next_pc is RESET_VEC when not jumping
//   flush_ifid          squash the IF/ID register
//   flush_idex          squash the ID/EX register (insert a bubble)
//   state               BOOT=0, RUN=1, MEMWAIT=2, HALT=3
//   stall_cycles        saturating count of cycles with stall=1
module fetch_ctrl #(
  parameter int unsigned     PC_W      = 6,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             jmp_req,
  input  logic [PC_W-1:0]  jmp_target,
  input  logic             halt,
  output logic             stall,
  output logic             jump_cs,
  output logic [PC_W-1:0]  Next_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_br_q, pend_br_d;
  logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   tgt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pend_v_q   <= 1'b0;
      pend_br_q  <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_br_q  <= pend_br_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_br_d  = pend_br_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        // Redirects and load-use keep RUN; halt and memory wait leave it.
        if (!br_taken && !jmp_req) begin
          if (halt) begin
            state_d = StHalt;
          end else if (!load_use && !imem_ready) begin
            state_d = StMemWait;
          end
        end
      end
      StMemWait: begin
        if (!imem_ready) begin
          // A branch is older than any jump behind it, so it always overwrites.
          if (br_taken) begin
            pend_v_d   = 1'b1;
            pend_br_d  = 1'b1;
            pend_tgt_d = br_target;
          end else if (jmp_req && !pend_v_q) begin
            pend_v_d   = 1'b1;
            pend_br_d  = 1'b0;
            pend_tgt_d = jmp_target;
          end
        end else begin
          pend_v_d  = 1'b0;
          pend_br_d = 1'b0;
          state_d   = StRun;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StBoot;
    endcase
  end

  // Output logic (Mealy). tgt stays at RESET_VEC unless a jump is issued.
  always_comb begin
    stall      = 1'b0;
    jump_cs    = 1'b0;
    tgt        = RESET_VEC;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state_q)
      StBoot: begin
        jump_cs    = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      StRun: begin
        if (br_taken) begin
          jump_cs    = 1'b1;
          tgt        = br_target;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (jmp_req) begin
          jump_cs    = 1'b1;
          tgt        = jmp_target;
          flush_ifid = 1'b1;
        end else if (halt) begin
          stall      = 1'b1;
          flush_ifid = 1'b1;
        end else if (load_use) begin
          stall      = 1'b1;
          flush_idex = 1'b1;
        end else if (!imem_ready) begin
          stall = 1'b1;
        end
      end
      StMemWait: begin
        if (!imem_ready) begin
          stall = 1'b1;
          if (br_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (jmp_req) begin
            flush_ifid = 1'b1;
          end
          if (load_use) begin
            flush_idex = 1'b1;
          end
        end else if (pend_v_q) begin
          jump_cs    = 1'b1;
          tgt        = pend_tgt_q;
          flush_ifid = 1'b1;
          flush_idex = load_use;
        end else if (br_taken) begin
          jump_cs    = 1'b1;
          tgt        = br_target;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (jmp_req) begin
          jump_cs    = 1'b1;
          tgt        = jmp_target;
          flush_ifid = 1'b1;
        end else begin
          stall      = load_use;
          flush_idex = load_use;
        end
      end
      StHalt:  stall = 1'b1;
      default: stall = 1'b1;
    endcase
  end

  assign Next_pc      = tgt;
  assign state        = state_q;
  assign stall_cycles = cnt_q;

  // The PC gives stall priority over jump, so both must never be requested together.
  a_jump_no_stall: assert property (@(posedge clk) disable iff (!rst_n) jump_cs |-> !stall);
  a_pend_br_valid: assert property (@(posedge clk) disable iff (!rst_n) pend_br_q |-> pend_v_q);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned     PC_W      = 6;
  localparam logic [PC_W-1:0] RESET_VEC = '0;
  localparam int unsigned     CNT_W     = 3;
  localparam int unsigned     CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            rst_n;
    logic            ready;
    logic            lu;
    logic            br;
    logic [PC_W-1:0] bt;
    logic            jr;
    logic [PC_W-1:0] jt;
    logic            halt;
  } stim_t;

  typedef struct packed {
    logic             stall;
    logic             jcs;
    logic [PC_W-1:0]  npc;
    logic             fi;
    logic             fx;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  pc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             imem_ready = 1'b0;
  logic             load_use = 1'b0;
  logic             br_taken = 1'b0;
  logic [PC_W-1:0]  br_target = '0;
  logic             jmp_req = 1'b0;
  logic [PC_W-1:0]  jmp_target = '0;
  logic             halt = 1'b0;
  logic             stall;
  logic             jump_cs;
  logic [PC_W-1:0]  Next_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  // The PC register this block controls
  logic [PC_W-1:0]  pc = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc_no = 0;
  exp_t exp_q[$];

  fetch_ctrl #(
    .PC_W      (PC_W),
    .RESET_VEC (RESET_VEC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_ready   (imem_ready),
    .load_use     (load_use),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_req      (jmp_req),
    .jmp_target   (jmp_target),
    .halt         (halt),
    .stall        (stall),
    .jump_cs      (jump_cs),
    .Next_pc      (Next_pc),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!stall) pc <= jump_cs ? Next_pc : pc + PC_W'(4);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
    end
  endfunction

  // Reference model: what the fetch stage should do this cycle, given the mode it is in
  int unsigned     m_mode = 0;  // 0 boot, 1 run, 2 waiting on memory, 3 halted
  bit              m_has = 0;   // a redirect remembered while memory was busy
  logic [PC_W-1:0] m_tgt = '0;
  int unsigned     m_cnt = 0;
  logic [PC_W-1:0] m_pc = '0;

  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    bit jmp;
    logic [PC_W-1:0] to;
    int unsigned nxt;
    e = '0;
    jmp = 0;
    to = RESET_VEC;
    if (!s.rst_n) begin
      m_mode = 0;
      m_has = 0;
      m_tgt = '0;
      m_cnt = 0;
    end
    nxt = m_mode;
    e.st = 2'(m_mode);
    e.cnt = CNT_W'(m_cnt);
    e.pc = m_pc;
    case (m_mode)
      0: begin
        jmp = 1; e.fi = 1; e.fx = 1;
        nxt = s.rst_n ? 1 : 0;
      end
      1: begin
        if (s.br) begin jmp = 1; to = s.bt; e.fi = 1; e.fx = 1; end
        else if (s.jr) begin jmp = 1; to = s.jt; e.fi = 1; end
        else if (s.halt) begin e.stall = 1; e.fi = 1; nxt = 3; end
        else if (s.lu) begin e.stall = 1; e.fx = 1; end
        else if (!s.ready) begin e.stall = 1; nxt = 2; end
      end
      2: begin
        if (!s.ready) begin
          e.stall = 1;
          if (s.br) begin m_has = 1; m_tgt = s.bt; e.fi = 1; e.fx = 1; end
          else if (s.jr) begin
            if (!m_has) begin m_has = 1; m_tgt = s.jt; end
            e.fi = 1;
          end
          if (s.lu) e.fx = 1;
        end else begin
          nxt = 1;
          if (m_has) begin jmp = 1; to = m_tgt; e.fi = 1; e.fx = s.lu; m_has = 0; end
          else if (s.br) begin jmp = 1; to = s.bt; e.fi = 1; e.fx = 1; end
          else if (s.jr) begin jmp = 1; to = s.jt; e.fi = 1; end
          else begin e.stall = s.lu; e.fx = s.lu; end
        end
      end
      default: e.stall = 1;
    endcase
    e.jcs = jmp;
    e.npc = to;
    if (e.stall && m_cnt < CNT_MAX) m_cnt++;
    if (!e.stall) m_pc = jmp ? to : m_pc + PC_W'(4);
    m_mode = nxt;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = s.rst_n;
    imem_ready = s.ready;
    load_use = s.lu;
    br_taken = s.br;
    br_target = s.bt;
    jmp_req = s.jr;
    jmp_target = s.jt;
    halt = s.halt;
    exp_q.push_back(model_step(s));
  endtask

  task automatic cyc(input logic rdy, input logic lu, input logic br, input int bt,
                     input logic jr, input int jt, input logic hl);
    stim_t s;
    s.rst_n = 1'b1; s.ready = rdy; s.lu = lu; s.br = br; s.bt = PC_W'(bt);
    s.jr = jr; s.jt = PC_W'(jt); s.halt = hl;
    drive(s);
  endtask

  task automatic rst_cyc();
    stim_t s;
    s = '0;
    drive(s);
  endtask

  // Monitor: outputs are presented every cycle; compare at mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("jump_cs", 32'(jump_cs), 32'(e.jcs));
        chk("Next_pc", 32'(Next_pc), 32'(e.npc));
        chk("flush_ifid", 32'(flush_ifid), 32'(e.fi));
        chk("flush_idex", 32'(flush_idex), 32'(e.fx));
        chk("state", 32'(state), 32'(e.st));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
        chk("pc", 32'(pc), 32'(e.pc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    int wait_cnt;
    // Boot
    rst_cyc();
    rst_cyc();
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("boot_jump_cs", 32'(jump_cs), 1);
    chk("boot_Next_pc", 32'(Next_pc), 0);
    chk("boot_state", 32'(state), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);          // pc 0
    cyc(1, 0, 0, 0, 0, 0, 0);          // pc 4
    // Load-use at pc 8 for two cycles
    cyc(1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_pc", 32'(pc), 8);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_flush_idex", 32'(flush_idex), 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_pc_hold", 32'(pc), 8);
    chk("lu_count", 32'(stall_cycles), 2);
    // Simultaneous branch and jump at pc 12
    cyc(1, 0, 1, 20, 1, 40, 0);
    @(negedge clk);
    chk("redir_pc", 32'(pc), 12);
    chk("redir_Next_pc", 32'(Next_pc), 20);
    chk("redir_flush_ifid", 32'(flush_ifid), 1);
    chk("redir_flush_idex", 32'(flush_idex), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("redir_pc_tgt", 32'(pc), 20);
    // Memory wait at pc 24 with a jump then a branch captured
    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_pc", 32'(pc), 24);
    cyc(0, 0, 0, 0, 1, 32, 0);
    cyc(0, 0, 1, 48, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_state", 32'(state), 2);
    chk("mw_stall", 32'(stall), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_jump_cs", 32'(jump_cs), 1);
    chk("mw_Next_pc", 32'(Next_pc), 48);
    // Halt at pc 48, then a branch that must be ignored
    cyc(1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("halt_pc", 32'(pc), 48);
    chk("halt_run_state", 32'(state), 1);
    cyc(1, 0, 1, 10, 0, 0, 0);
    @(negedge clk);
    chk("halt_state", 32'(state), 3);
    chk("halt_stall", 32'(stall), 1);
    chk("halt_br_ignored", 32'(jump_cs), 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("count_saturated", 32'(stall_cycles), CNT_MAX);
    rst_cyc();
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(stall_cycles), 0);
    chk("rst_stall", 32'(stall), 0);

    // Randomized traffic, including mid-operation resets
    for (int i = 0; i < 4000; i++) begin
      s.rst_n = ($urandom_range(99) >= 3);
      s.ready = ($urandom_range(99) < 70);
      s.lu = ($urandom_range(99) < 15);
      s.br = ($urandom_range(99) < 12);
      s.bt = PC_W'($urandom);
      s.jr = ($urandom_range(99) < 12);
      s.jt = PC_W'($urandom);
      s.halt = ($urandom_range(99) < 3);
      drive(s);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
